// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch front end.
// FETCH_ADEL_EN adds an address-error flag to each buffered entry.
package fetch_unit_pkg;

  typedef logic [31:0] word_t;

  localparam word_t DEFAULT_RESET_PC = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
`ifdef FETCH_ADEL_EN
    logic  adel;
`endif
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_fifo.sv
// Small circular buffer of fetched {pc, instr} entries with flush.
// Entry layout follows FETCH_ADEL_EN through fetch_entry_t.
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push_i,
  input  fetch_entry_t                push_data_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output fetch_entry_t                head_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);

  fetch_entry_t  mem_q [FIFO_DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      // Keep the read pointer so the (empty) head stays stable after a flush.
      wr_ptr_q <= rd_ptr_q;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding bus requests, buffered output to decode.
// FETCH_ADEL_EN: misaligned PCs produce an address-error entry (out_adel) instead of a request.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter word_t       RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        ireq_ready,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output word_t       out_instr
`ifdef FETCH_ADEL_EN
  ,
  output logic        out_adel
`endif
);

  localparam int unsigned      CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t  state_q, state_d;
  word_t         pc_q, pc_d;
  word_t         req_pc_q, req_pc_d;
  logic          req_en;
  logic          space;
  logic          misaligned;
  logic          push, pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [CW-1:0] fifo_count;

`ifdef FETCH_ADEL_EN
  logic adel_stall_q, adel_stall_d;
  assign misaligned = (pc_q[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign space = (fifo_count < DEPTH_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      pc_q     <= RESET_PC;
      req_pc_q <= '0;
`ifdef FETCH_ADEL_EN
      adel_stall_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
`ifdef FETCH_ADEL_EN
      adel_stall_q <= adel_stall_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    req_en     = 1'b0;
    push       = 1'b0;
    push_entry = '0;
`ifdef FETCH_ADEL_EN
    adel_stall_d = adel_stall_q;
`endif
    if (redirect_valid) begin
      // A redirect outranks everything; an outstanding request must be drained.
`ifdef FETCH_ADEL_EN
      pc_d         = redirect_pc;
      adel_stall_d = 1'b0;
`else
      pc_d = redirect_pc & 32'hffff_fffc;
`endif
      unique case (state_q)
        WAIT:    state_d = iresp_valid ? IDLE : DRAIN;
        DRAIN:   state_d = iresp_valid ? IDLE : DRAIN;
        default: state_d = IDLE;
      endcase
    end else begin
      unique case (state_q)
        IDLE: begin
          if (space && !misaligned) begin
            req_en = 1'b1;
            if (ireq_ready) begin
              req_pc_d = pc_q;
              pc_d     = pc_q + 32'd4;
              state_d  = WAIT;
            end
          end
`ifdef FETCH_ADEL_EN
          if (space && misaligned && !adel_stall_q) begin
            push            = 1'b1;
            push_entry.pc   = pc_q;
            push_entry.adel = 1'b1;
            adel_stall_d    = 1'b1;
          end
`endif
        end
        WAIT: begin
          if (iresp_valid) begin
            push             = 1'b1;
            push_entry.pc    = req_pc_q;
            push_entry.instr = iresp_data;
            state_d          = IDLE;
          end
        end
        DRAIN: begin
          if (iresp_valid) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .flush_i    (redirect_valid),
    .count_o    (fifo_count),
    .head_o     (head)
  );

  assign ireq_valid = req_en & ~reset;
`ifdef FETCH_ADEL_EN
  assign ireq_addr  = pc_q;
  assign out_adel   = head.adel & ~reset;
`else
  assign ireq_addr  = pc_q & 32'hffff_fffc;
`endif
  assign out_valid  = (fifo_count != '0) & ~reset;
  assign pop        = out_valid & out_ready;
  assign out_pc     = reset ? '0 : head.pc;
  assign out_instr  = reset ? '0 : head.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected requests/outputs queued by stimulus, checked by monitors.
module tb_fetch_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready = 1'b0;
  logic        iresp_valid = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef FETCH_ADEL_EN
  logic        out_adel;
  localparam logic [31:0] MIS_BASE = 32'h8000_0200;
`else
  localparam logic [31:0] MIS_BASE = 32'h8000_0400;
`endif

  exp_t        exp_out[$];
  logic [31:0] exp_req[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          acc_count = 0;
  int          resp_lat = 1;
  logic        force_bad = 1'b0;

  fetch_unit #(
    .RESET_PC  (32'hbfc0_0000),
    .FIFO_DEPTH(2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .ireq_valid    (ireq_valid),
    .ireq_addr     (ireq_addr),
    .ireq_ready    (ireq_ready),
    .iresp_valid   (iresp_valid),
    .iresp_data    (iresp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
    .out_instr     (out_instr)
`ifdef FETCH_ADEL_EN
    ,
    .out_adel      (out_adel)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1);
  end

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'ha5a5_0f0f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Bus model: handshakes sampled mid-cycle, responses driven 1ns after the edge.
  initial begin : bus
    logic        acc;
    logic        rst;
    logic [31:0] a;
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    pend = 1'b0;
    cnt = 0;
    paddr = '0;
    forever begin
      @(negedge clk);
      acc = ireq_valid && ireq_ready && !reset;
      rst = reset;
      a = ireq_addr;
      if (acc) begin
        acc_count++;
        if (exp_req.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ireq_unexpected: got request %08h expected none", a);
        end else begin
          chk("ireq_addr", a, exp_req.pop_front());
        end
      end
      @(posedge clk);
      #1;
      iresp_valid = 1'b0;
      if (rst) pend = 1'b0;
      if (acc) begin
        pend = 1'b1;
        cnt = resp_lat;
        paddr = a;
      end
      if (pend) begin
        if (cnt <= 1) begin
          iresp_valid = 1'b1;
          iresp_data = force_bad ? 32'hdead_beef : instr_of(paddr);
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_out.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL out_unexpected: got pc %08h instr %08h expected none", out_pc, out_instr);
      end else begin
        exp_t e;
        e = exp_out.pop_front();
        chk("out_pc", out_pc, e.pc);
        chk("out_instr", out_instr, e.instr);
`ifdef FETCH_ADEL_EN
        chk("out_adel", 32'(out_adel), 32'(e.adel));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic expect_fetch(input logic [31:0] a);
    exp_t e;
    e.pc = a;
    e.instr = instr_of(a);
    e.adel = 1'b0;
    exp_req.push_back(a);
    exp_out.push_back(e);
  endtask

  task automatic fetch_n(input int n);
    int target;
    int t;
    target = acc_count + n;
    t = 0;
    ireq_ready = 1'b1;
    while (acc_count < target && t < 100) begin
      step();
      t++;
    end
    ireq_ready = 1'b0;
    chk("fetch_count", 32'(acc_count), 32'(target));
  endtask

  task automatic drain();
    int t;
    t = 0;
    out_ready = 1'b1;
    while (exp_out.size() != 0 && t < 100) begin
      step();
      t++;
    end
    chk("drain_left", 32'(exp_out.size()), 32'd0);
    sample();
    chk("empty_after_drain", 32'(out_valid), 32'd0);
    step();
  endtask

  task automatic redirect(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_pc = a;
    step();
    redirect_valid = 1'b0;
  endtask

  initial begin
    int start;
    exp_t e;

    // Reset cycle outputs
    step();
    sample();
    chk("rst_ireq_valid", 32'(ireq_valid), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    step();
    reset = 1'b0;
    sample();
    chk("post_rst_ireq_valid", 32'(ireq_valid), 32'd1);
    chk("post_rst_ireq_addr", ireq_addr, 32'hbfc0_0000);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    step();

    // Streaming fetch, 1-cycle bus
    out_ready = 1'b1;
    expect_fetch(32'hbfc0_0000);
    expect_fetch(32'hbfc0_0004);
    expect_fetch(32'hbfc0_0008);
    fetch_n(3);
    drain();

    // Backpressure: only two entries may be buffered
    out_ready = 1'b0;
    exp_req.push_back(32'hbfc0_000c);
    exp_req.push_back(32'hbfc0_0010);
    start = acc_count;
    ireq_ready = 1'b1;
    repeat (10) step();
    ireq_ready = 1'b0;
    sample();
    chk("full_accepts", 32'(acc_count - start), 32'd2);
    chk("full_no_req", 32'(ireq_valid), 32'd0);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    step();
    e.adel = 1'b0;
    e.pc = 32'hbfc0_000c; e.instr = instr_of(e.pc); exp_out.push_back(e);
    e.pc = 32'hbfc0_0010; e.instr = instr_of(e.pc); exp_out.push_back(e);
    drain();
    expect_fetch(32'hbfc0_0014);
    fetch_n(1);
    drain();

    // Redirect while waiting; late response must be dropped
    exp_req.push_back(32'hbfc0_0018);
    resp_lat = 3;
    force_bad = 1'b1;
    fetch_n(1);
    redirect(32'h8000_0100);
    sample();
    chk("drain_no_req", 32'(ireq_valid), 32'd0);
    step();
    for (int t = 0; t < 20 && !ireq_valid; t++) step();
    force_bad = 1'b0;
    resp_lat = 1;
    chk("redirect_addr", ireq_addr, 32'h8000_0100);
    expect_fetch(32'h8000_0100);
    expect_fetch(32'h8000_0104);
    fetch_n(2);
    drain();

    // Redirect in the same cycle as the response
    exp_req.push_back(32'h8000_0108);
    force_bad = 1'b1;
    fetch_n(1);
    redirect(32'h8000_0200);
    force_bad = 1'b0;
    sample();
    chk("same_cyc_ireq_valid", 32'(ireq_valid), 32'd1);
    chk("same_cyc_ireq_addr", ireq_addr, 32'h8000_0200);
    chk("same_cyc_out_valid", 32'(out_valid), 32'd0);
    step();
    expect_fetch(32'h8000_0200);
    fetch_n(1);
    drain();

    // Redirect flushes buffered entries
    out_ready = 1'b0;
    exp_req.push_back(32'h8000_0204);
    exp_req.push_back(32'h8000_0208);
    fetch_n(2);
    repeat (3) step();
    sample();
    chk("pre_flush_out_valid", 32'(out_valid), 32'd1);
    step();
    redirect(32'h8000_0300);
    sample();
    chk("flushed_out_valid", 32'(out_valid), 32'd0);
    step();
    expect_fetch(32'h8000_0300);
    out_ready = 1'b1;
    fetch_n(1);
    drain();

    // Request held while the bus stalls
    for (int i = 0; i < 5; i++) begin
      sample();
      chk("hold_ireq_valid", 32'(ireq_valid), 32'd1);
      chk("hold_ireq_addr", ireq_addr, 32'h8000_0304);
      step();
    end
    expect_fetch(32'h8000_0304);
    fetch_n(1);
    drain();

    // Misaligned redirect target
`ifdef FETCH_ADEL_EN
    e.pc = 32'h8000_0102; e.instr = 32'h0; e.adel = 1'b1;
    exp_out.push_back(e);
    out_ready = 1'b1;
    ireq_ready = 1'b1;
    redirect(32'h8000_0102);
    for (int i = 0; i < 6; i++) begin
      sample();
      chk("adel_no_req", 32'(ireq_valid), 32'd0);
      step();
    end
    ireq_ready = 1'b0;
    chk("adel_entry_seen", 32'(exp_out.size()), 32'd0);
    redirect(32'h8000_0200);
    expect_fetch(32'h8000_0200);
    fetch_n(1);
    drain();
`else
    redirect(32'h8000_0402);
    sample();
    chk("aligned_ireq_addr", ireq_addr, 32'h8000_0400);
    step();
    expect_fetch(32'h8000_0400);
    fetch_n(1);
    drain();
`endif

    // Reset while a slow response is outstanding
    exp_req.push_back(MIS_BASE + 32'd4);
    resp_lat = 3;
    fetch_n(1);
    reset = 1'b1;
    sample();
    chk("mid_rst_ireq_valid", 32'(ireq_valid), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    step();
    reset = 1'b0;
    sample();
    chk("after_rst_ireq_addr", ireq_addr, 32'hbfc0_0000);
    chk("after_rst_ireq_valid", 32'(ireq_valid), 32'd1);
    step();
    repeat (5) step();
    sample();
    chk("after_rst_out_valid", 32'(out_valid), 32'd0);
    chk("req_queue_left", 32'(exp_req.size()), 32'd0);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
